// File: rtl/btn_conditioner_multi.sv
// btn_conditioner_multi: N independent push-button channels, each with a 2-FF
// synchroniser, a debounce filter, press/release edge pulses and long-press
// detection. All outputs are registered.
// Auto-repeat pulses are built only when BTN_AUTOREPEAT_EN is defined;
// otherwise o_repeat_pulse is tied to 0.
module btn_conditioner_multi #(
  parameter int unsigned N_BTN        = 4,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned LONG_CYC     = 100_000_000,
  parameter int unsigned REPEAT_CYC   = 20_000_000,
  parameter int unsigned CNT_W        = 27
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] i_btn_in,
  output logic [N_BTN-1:0] o_btn_level,
  output logic [N_BTN-1:0] o_press_pulse,
  output logic [N_BTN-1:0] o_release_pulse,
  output logic [N_BTN-1:0] o_long_pulse,
  output logic [N_BTN-1:0] o_repeat_pulse
);

  typedef enum logic [1:0] {StReleased, StHeld, StLongHeld} state_e;

  localparam logic [CNT_W-1:0] DebLast  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_CYC - 1);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RepLast  = CNT_W'(REPEAT_CYC - 1);
`endif

  // Zero-length thresholds would make the compare values wrap.
  if (N_BTN < 1 || DEBOUNCE_CYC < 1 || LONG_CYC < 1 || REPEAT_CYC < 1) begin : g_param_check
    $error("btn_conditioner_multi: N_BTN and all cycle counts must be >= 1");
  end

  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;

  // Two-flop synchroniser for the raw asynchronous button levels
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_btn_in;
      r_sync2 <= r_sync1;
    end
  end

`ifndef BTN_AUTOREPEAT_EN
  assign o_repeat_pulse = '0;
`endif

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             r_long;
    logic [CNT_W-1:0] r_deb_cnt;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] w_hold_cnt_d;
    state_e           r_state;
    state_e           w_state_d;
    logic             w_differ;
    logic             w_accept;
    logic             w_press;
    logic             w_release;
    logic             w_long;
`ifdef BTN_AUTOREPEAT_EN
    logic             r_repeat;
    logic             w_repeat;
`endif

    assign w_differ  = r_sync2[g] ^ r_level;
    assign w_accept  = w_differ && (r_deb_cnt == DebLast);
    assign w_press   = w_accept & ~r_level;
    assign w_release = w_accept & r_level;

    // Debounce: accept a new level after DEBOUNCE_CYC consecutive mismatching samples
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_level   <= 1'b0;
        r_deb_cnt <= '0;
      end else if (!w_differ) begin
        r_deb_cnt <= '0;
      end else if (w_accept) begin
        r_level   <= ~r_level;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + CNT_W'(1);
      end
    end

    // Channel FSM state and hold counter register
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_state    <= StReleased;
        r_hold_cnt <= '0;
      end else begin
        r_state    <= w_state_d;
        r_hold_cnt <= w_hold_cnt_d;
      end
    end

    // Next state: an accepted release always takes priority over threshold events
    always_comb begin
      w_state_d    = r_state;
      w_hold_cnt_d = r_hold_cnt;
      unique case (r_state)
        StReleased: begin
          if (w_press) begin
            w_state_d    = StHeld;
            w_hold_cnt_d = '0;
          end
        end
        StHeld: begin
          if (w_release) begin
            w_state_d    = StReleased;
            w_hold_cnt_d = '0;
          end else if (r_hold_cnt == LongLast) begin
            w_state_d    = StLongHeld;
            w_hold_cnt_d = '0;
          end else begin
            w_hold_cnt_d = r_hold_cnt + CNT_W'(1);
          end
        end
        StLongHeld: begin
          if (w_release) begin
            w_state_d    = StReleased;
            w_hold_cnt_d = '0;
          end
`ifdef BTN_AUTOREPEAT_EN
          else if (r_hold_cnt == RepLast) begin
            w_hold_cnt_d = '0;
          end else begin
            w_hold_cnt_d = r_hold_cnt + CNT_W'(1);
          end
`endif
        end
        default: begin
          w_state_d    = StReleased;
          w_hold_cnt_d = '0;
        end
      endcase
    end

    // Output decode for the threshold pulses
    always_comb begin
      w_long = (r_state == StHeld) && !w_release && (r_hold_cnt == LongLast);
`ifdef BTN_AUTOREPEAT_EN
      w_repeat = (r_state == StLongHeld) && !w_release && (r_hold_cnt == RepLast);
`endif
    end

    // Register all pulses so they line up with the new debounced level
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_long    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        r_repeat  <= 1'b0;
`endif
      end else begin
        r_press   <= w_press;
        r_release <= w_release;
        r_long    <= w_long;
`ifdef BTN_AUTOREPEAT_EN
        r_repeat  <= w_repeat;
`endif
      end
    end

    assign o_btn_level[g]     = r_level;
    assign o_press_pulse[g]   = r_press;
    assign o_release_pulse[g] = r_release;
    assign o_long_pulse[g]    = r_long;
`ifdef BTN_AUTOREPEAT_EN
    assign o_repeat_pulse[g]  = r_repeat;
`endif
  end

endmodule

// File: doc/btn_conditioner_multi.md
Name: btn_conditioner_multi

Overview:
- Parametrised N-channel push-button front end: per-channel 2-FF synchroniser, debounce filter, press/release edge pulses and long-press detection.
- Optional auto-repeat pulse generation.
- Sits between raw board buttons and control FSMs such as shift-register and counter controllers.
- Replaces fixed 2-button debounce and rise-edge logic; every channel is independent and identical.

Parameters:
- N_BTN, 4, number of button channels (>=1).
- DEBOUNCE_CYC, 1_000_000, consecutive stable cycles needed to accept a level change (10 ms @100 MHz; >=1).
- LONG_CYC, 100_000_000, cycles the debounced level must stay high before long_pulse (1 s; >=1).
- REPEAT_CYC, 20_000_000, auto-repeat period after long press (200 ms; >=1; used only with macro).
- CNT_W, 27, width of the per-channel counters; must hold max(DEBOUNCE_CYC, LONG_CYC, REPEAT_CYC)-1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- btn_in  in  N_BTN  raw asynchronous button levels, 1 = pressed.
- btn_level  out  N_BTN  debounced level.
- press_pulse  out  N_BTN  1-cycle pulse on accepted 0->1.
- release_pulse  out  N_BTN  1-cycle pulse on accepted 1->0.
- long_pulse  out  N_BTN  1-cycle pulse at long-press threshold.
- repeat_pulse  out  N_BTN  1-cycle auto-repeat pulses (0 without macro).

Behaviour:
- Reset: all outputs 0, synchronisers 0, all counters 0, every channel FSM in RELEASED. All outputs are registered.
- Synchroniser: btn_in passes through 2 flops per channel; s = second flop output.
- Debounce, per channel, deb_cnt:
  - s == btn_level: deb_cnt <= 0.
  - s != btn_level and deb_cnt == DEBOUNCE_CYC-1: btn_level toggles, deb_cnt <= 0.
  - Otherwise deb_cnt increments.
- Debounce latency: if btn_in is first sampled at a new level at edge t0 and stays there, btn_level changes after edge t0+DEBOUNCE_CYC+1.
- A glitch shorter than DEBOUNCE_CYC sampled cycles produces no output change; deb_cnt restarts at 0 whenever s matches btn_level again.
- press_pulse/release_pulse assert in the same cycle btn_level takes its new value, for exactly 1 cycle.
- Channel FSM states: RELEASED, HELD, LONG_HELD.
  - RELEASED -> HELD on accepted press; hold_cnt <= 0.
  - HELD: hold_cnt increments each cycle. When hold_cnt == LONG_CYC-1, next edge asserts long_pulse for 1 cycle, moves to LONG_HELD, hold_cnt <= 0.
  - Timing: long_pulse is high after edge e_p+LONG_CYC, where e_p is the edge raising press_pulse.
  - HELD or LONG_HELD -> RELEASED on accepted release; hold_cnt <= 0.
  - If release is accepted on the same edge the long threshold would fire, release wins and long_pulse stays 0.
- long_pulse fires at most once per press.
- Channels are fully independent; simultaneous events on several channels give simultaneous pulses.
- Reset mid-operation aborts everything immediately, with no release_pulse. A button still held at reset deassertion is re-debounced and yields a fresh press_pulse after the normal latency.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - In LONG_HELD, hold_cnt counts REPEAT_CYC cycles; repeat_pulse asserts for 1 cycle after edges e_p+LONG_CYC+k*REPEAT_CYC, k>=1, while held.
  - No repeat_pulse is generated on the long_pulse cycle itself.
  - Release stops repeats immediately; if release and repeat coincide, release wins.
- Undefined: repeat_pulse is constant 0 and no repeat logic is synthesised; all other behaviour is unchanged.

Test Plan (bench parameters: N_BTN=2, DEBOUNCE_CYC=4, LONG_CYC=10, REPEAT_CYC=3):
- Clean press on ch0, sampled at edge 0 and held -> btn_level[0]=1 and press_pulse[0]=1 for 1 cycle after edge 5; ch1 outputs stay 0.
- Ch0 glitch high for 3 cycles, then low -> no change on btn_level or any pulse; a subsequent 4-cycle-stable press is accepted normally.
- Hold ch1 for 20 cycles after press accepted at edge e_p -> long_pulse[1] high for 1 cycle after edge e_p+10; release gives release_pulse[1] 4+1 cycles after the raw low is sampled.
- With BTN_AUTOREPEAT_EN, hold ch0 for 20 cycles past press -> repeat_pulse[0] after edges e_p+13, e_p+16, e_p+19; stops on release. Without the macro, repeat_pulse stays 0.
- Both channels pressed on the same edge -> press_pulse = 2'b11 in one cycle; release accepted exactly at the long threshold -> release_pulse=1, long_pulse=0.
- Assert reset while ch0 is in LONG_HELD, keep btn_in[0]=1, deassert -> all outputs 0 during reset; press_pulse[0] reappears 2+4 cycles after deassertion, with no release_pulse.
